// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data BRAM and the IO bus and produces the MEM/WB bundle.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses (adds misalign_o).
module mem_stage_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_i,
  input  logic              mem_or_io_to_reg_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              io_read_i,
  input  logic              io_write_i,
  input  logic [1:0]        byte_or_word_i,
  input  logic              load_unsigned_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_en_o,
  output logic [3:0]        dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  output logic              io_req_o,
  output logic              io_we_o,
  output logic [31:0]       io_addr_o,
  output logic [31:0]       io_wdata_o,
  input  logic              io_ack_i,
  input  logic [31:0]       io_rdata_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic              wb_reg_write_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              io_timeout_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic             misalign_o
`endif
);

  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       rd_reg;
  logic [1:0]       size_reg;
  logic [1:0]       off_reg;
  logic             unsigned_reg;
  logic             to_reg_reg;
  logic             reg_write_reg;
  logic             write_reg;
  logic [31:0]      alu_reg;

  logic        is_io;
  logic        is_mem;
  logic        is_write;
  logic        trap;
  logic        timeout_hit;
  logic [1:0]  off;
  logic [3:0]  lanes;
  logic [31:0] store_data;

  // Sub-word extraction: shift the addressed lane down, then extend from its top bit.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                          input logic [1:0] o, input logic u);
    logic [31:0] s;
    s = d >> {o, 3'b000};
    if (sz[1]) return d;
    if (sz[0]) return {{16{s[15] & ~u}}, s[15:0]};
    return {{24{s[7] & ~u}}, s[7:0]};
  endfunction

  assign is_io       = io_read_i | io_write_i;
  assign is_mem      = !is_io && (mem_read_i | mem_write_i);
  assign is_write    = is_io ? io_write_i : mem_write_i;
  assign timeout_hit = (cnt_reg == CNT_W'(IO_TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((byte_or_word_i == 2'b01) && alu_result_i[0]) ||
                      (byte_or_word_i[1] && (alu_result_i[1:0] != 2'b00));
  assign trap = misaligned && (is_io || is_mem);
`else
  assign trap = 1'b0;
`endif

  // Lane offset with the low address bits dropped for halves and words.
  always_comb begin
    off        = alu_result_i[1:0];
    lanes      = 4'b1111;
    store_data = wdata_i;
    if (byte_or_word_i[1]) begin
      off = 2'b00;
    end else if (byte_or_word_i[0]) begin
      off        = {alu_result_i[1], 1'b0};
      lanes      = 4'b0011 << off;
      store_data = {2{wdata_i[15:0]}};
    end else begin
      lanes      = 4'b0001 << off;
      store_data = {4{wdata_i[7:0]}};
    end
  end

  assign dmem_en_o    = rst_n && (state_reg == IDLE) && is_mem && !trap;
  assign dmem_we_o    = (dmem_en_o && is_write) ? lanes : 4'b0000;
  assign dmem_addr_o  = alu_result_i[ADDR_W+1:2];
  assign dmem_wdata_o = store_data;

  // Stall drops in the completing cycle so upstream advances exactly once.
  always_comb begin
    stall_o = 1'b0;
    if (rst_n) begin
      if (state_reg == IDLE)
        stall_o = !trap && (is_io || (is_mem && !is_write));
      else if (state_reg == IO_WAIT)
        stall_o = !io_ack_i && !timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rd_reg         <= '0;
      size_reg       <= '0;
      off_reg        <= '0;
      unsigned_reg   <= 1'b0;
      to_reg_reg     <= 1'b0;
      reg_write_reg  <= 1'b0;
      write_reg      <= 1'b0;
      alu_reg        <= '0;
      io_req_o       <= 1'b0;
      io_we_o        <= 1'b0;
      io_addr_o      <= '0;
      io_wdata_o     <= '0;
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      io_timeout_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o     <= 1'b0;
`endif
    end else begin
      wb_valid_o   <= 1'b0;
      io_timeout_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o   <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          rd_reg        <= rd_i;
          size_reg      <= byte_or_word_i;
          off_reg       <= off;
          unsigned_reg  <= load_unsigned_i;
          to_reg_reg    <= mem_or_io_to_reg_i;
          reg_write_reg <= reg_write_i;
          write_reg     <= is_write;
          alu_reg       <= alu_result_i;
          if (trap) begin
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= rd_i;
            wb_data_o      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o     <= 1'b1;
`endif
          end else if (is_io) begin
            io_req_o   <= 1'b1;
            io_we_o    <= io_write_i;
            io_addr_o  <= {alu_result_i[31:2], off};
            io_wdata_o <= wdata_i;
            cnt_reg    <= '0;
            state_reg  <= IO_WAIT;
          end else if (is_mem && !is_write) begin
            state_reg <= MEM_RD;
          end else begin
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= is_mem ? 1'b0 : reg_write_i;
            wb_rd_o        <= rd_i;
            wb_data_o      <= alu_result_i;
          end
        end
        MEM_RD: begin
          wb_valid_o     <= 1'b1;
          wb_reg_write_o <= reg_write_reg;
          wb_rd_o        <= rd_reg;
          wb_data_o      <= to_reg_reg ? extract(dmem_rdata_i, size_reg, off_reg, unsigned_reg)
                                       : alu_reg;
          state_reg      <= IDLE;
        end
        IO_WAIT: begin
          if (io_ack_i || timeout_hit) begin
            io_req_o       <= 1'b0;
            io_we_o        <= 1'b0;
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= reg_write_reg && !write_reg;
            wb_rd_o        <= rd_reg;
            state_reg      <= IDLE;
            if (io_ack_i) begin
              wb_data_o <= (to_reg_reg && !write_reg)
                           ? extract(io_rdata_i, size_reg, off_reg, unsigned_reg) : alu_reg;
            end else begin
              wb_data_o    <= '0;
              io_timeout_o <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a byte-array reference model.
// Honours MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_stage_ctrl;
  localparam int ADDR_W     = 14;
  localparam int IO_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reg_write_i, mem_or_io_to_reg_i;
  logic              mem_read_i, mem_write_i, io_read_i, io_write_i;
  logic [1:0]        byte_or_word_i;
  logic              load_unsigned_i;
  logic [31:0]       alu_result_i, wdata_i;
  logic [4:0]        rd_i;
  logic              dmem_en_o;
  logic [3:0]        dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [31:0]       dmem_wdata_o, dmem_rdata_i;
  logic              io_req_o, io_we_o;
  logic [31:0]       io_addr_o, io_wdata_o;
  logic              io_ack_i;
  logic [31:0]       io_rdata_i;
  logic              stall_o, wb_valid_o, wb_reg_write_o;
  logic [4:0]        wb_rd_o;
  logic [31:0]       wb_data_o;
  logic              io_timeout_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] bram [16];
  logic [7:0]  ref_bytes [64];

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_i(reg_write_i), .mem_or_io_to_reg_i(mem_or_io_to_reg_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .io_read_i(io_read_i), .io_write_i(io_write_i),
    .byte_or_word_i(byte_or_word_i), .load_unsigned_i(load_unsigned_i),
    .alu_result_i(alu_result_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .dmem_en_o(dmem_en_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .io_req_o(io_req_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o),
    .io_wdata_o(io_wdata_o), .io_ack_i(io_ack_i), .io_rdata_i(io_rdata_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .io_timeout_o(io_timeout_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Simple BRAM: registered read, byte-lane writes.
  always @(posedge clk) begin
    if (dmem_en_o) begin
      dmem_rdata_i <= bram[dmem_addr_o[3:0]];
      for (int b = 0; b < 4; b++)
        if (dmem_we_o[b]) bram[dmem_addr_o[3:0]][8*b +: 8] <= dmem_wdata_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference load: take n little-endian bytes at byte offset a%4, extend arithmetically.
  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] a,
                                           input int unsigned n, input bit uns);
    longint v, lim;
    v   = longint'(word >> (8 * (a % 4)));
    lim = longint'(1) << (8 * n);
    v   = v % lim;
    if (!uns && n < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  // flags = {io_write, io_read, mem_write, mem_read}. Called and returns at a negedge.
  task automatic do_txn(input logic [3:0] flags, input logic [31:0] addr, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd, input bit rw, input logic [4:0] rd,
                        input bit to_reg, input int ack_at, input logic [31:0] iord);
    bit          is_io, is_mem, wr, mis, tmo;
    int unsigned n;
    logic [31:0] aaddr, wbase, exp_data, word, exp_wd;
    logic [3:0]  exp_we;
    int          stalls, done_cyc;
    is_io  = flags[3] | flags[2];
    is_mem = !is_io && (flags[1] | flags[0]);
    wr     = is_io ? flags[3] : flags[1];
    n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis    = (addr % n) != 0;
    aaddr  = addr - (addr % n);
    wbase  = aaddr - (aaddr % 4);
    io_write_i = flags[3]; io_read_i = flags[2]; mem_write_i = flags[1]; mem_read_i = flags[0];
    byte_or_word_i = sz; load_unsigned_i = uns; alu_result_i = addr; wdata_i = wd;
    reg_write_i = rw; rd_i = rd; mem_or_io_to_reg_i = to_reg; io_ack_i = 1'b0; io_rdata_i = iord;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((is_io || is_mem) && mis) begin
      check("trap_stall", 32'(stall_o), 0);
      check("trap_dmem_en", 32'(dmem_en_o), 0);
      @(negedge clk);
      check("trap_wb_valid", 32'(wb_valid_o), 1);
      check("trap_misalign", 32'(misalign_o), 1);
      check("trap_reg_write", 32'(wb_reg_write_o), 0);
      check("trap_io_req", 32'(io_req_o), 0);
      $display("txn trap addr=%h bytes=%0d", addr, n);
      return;
    end
`endif
    if (!is_io && !is_mem) begin
      check("nop_stall", 32'(stall_o), 0);
      check("nop_dmem_en", 32'(dmem_en_o), 0);
      @(negedge clk);
      check("nop_wb_valid", 32'(wb_valid_o), 1);
      check("nop_wb_data", wb_data_o, addr);
      check("nop_reg_write", 32'(wb_reg_write_o), 32'(rw));
      check("nop_rd", 32'(wb_rd_o), 32'(rd));
      $display("txn nop alu=%h wb_data=%h", addr, wb_data_o);
    end else if (is_mem && wr) begin
      exp_we = 4'b0000;
      for (int i = 0; i < int'(n); i++) begin
        exp_we[int'(aaddr % 4) + i] = 1'b1;
        ref_bytes[int'(aaddr) + i]  = wd[8*i +: 8];
      end
      for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % int'(n)) +: 8];
      check("st_stall", 32'(stall_o), 0);
      check("st_dmem_en", 32'(dmem_en_o), 1);
      check("st_we", 32'(dmem_we_o), 32'(exp_we));
      check("st_wdata", dmem_wdata_o, exp_wd);
      check("st_addr", 32'(dmem_addr_o), aaddr >> 2);
      @(negedge clk);
      check("st_wb_valid", 32'(wb_valid_o), 1);
      check("st_reg_write", 32'(wb_reg_write_o), 0);
      $display("txn store addr=%h bytes=%0d data=%h we=%b", addr, n, wd, exp_we);
    end else if (is_mem) begin
      word = {ref_bytes[wbase+3], ref_bytes[wbase+2], ref_bytes[wbase+1], ref_bytes[wbase]};
      exp_data = to_reg ? load_val(word, aaddr, n, uns) : addr;
      check("ld_stall", 32'(stall_o), 1);
      check("ld_dmem_en", 32'(dmem_en_o), 1);
      check("ld_we", 32'(dmem_we_o), 0);
      check("ld_addr", 32'(dmem_addr_o), aaddr >> 2);
      @(negedge clk);
      check("ld_stall_rd", 32'(stall_o), 0);
      check("ld_early_valid", 32'(wb_valid_o), 0);
      @(negedge clk);
      check("ld_wb_valid", 32'(wb_valid_o), 1);
      check("ld_wb_data", wb_data_o, exp_data);
      check("ld_reg_write", 32'(wb_reg_write_o), 32'(rw));
      check("ld_rd", 32'(wb_rd_o), 32'(rd));
      $display("txn load addr=%h bytes=%0d uns=%0b wb_data=%h", addr, n, uns, wb_data_o);
    end else begin
      tmo      = !(ack_at >= 1 && ack_at <= IO_TIMEOUT);
      done_cyc = tmo ? IO_TIMEOUT : ack_at;
      stalls   = int'(stall_o);
      check("io_dmem_en", 32'(dmem_en_o), 0);
      for (int k = 1; k <= done_cyc; k++) begin
        @(negedge clk);
        if (k == 1) begin
          check("io_req", 32'(io_req_o), 1);
          check("io_we", 32'(io_we_o), 32'(wr));
          check("io_addr", io_addr_o, aaddr);
          if (wr) check("io_wdata", io_wdata_o, wd);
        end
        io_ack_i = (k == ack_at);
        #1;
        stalls += int'(stall_o);
      end
      @(negedge clk);
      io_ack_i = 1'b0;
      if (tmo) exp_data = 32'h0;
      else if (to_reg) exp_data = load_val(iord, aaddr, n, uns);
      else exp_data = addr;
      check("io_stall_cycles", 32'(stalls), 32'(done_cyc));
      check("io_wb_valid", 32'(wb_valid_o), 1);
      check("io_req_drop", 32'(io_req_o), 0);
      check("io_timeout", 32'(io_timeout_o), 32'(tmo));
      check("io_reg_write", 32'(wb_reg_write_o), wr ? 32'(0) : 32'(rw));
      if (tmo || !wr) check("io_wb_data", wb_data_o, exp_data);
      if (!wr) check("io_rd", 32'(wb_rd_o), 32'(rd));
      $display("txn io wr=%0b addr=%h ack_at=%0d timeout=%0b wb_data=%h", wr, addr, ack_at, tmo, wb_data_o);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [3:0]  fl;
    logic [31:0] a;
    rst_n = 1'b0;
    {io_write_i, io_read_i, mem_write_i, mem_read_i} = 4'b0000;
    byte_or_word_i = 2'b10; load_unsigned_i = 1'b0; alu_result_i = '0; wdata_i = '0;
    reg_write_i = 1'b0; rd_i = '0; mem_or_io_to_reg_i = 1'b0; io_ack_i = 1'b0; io_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_dmem_en", 32'(dmem_en_o), 0);
    check("rst_wb_valid", 32'(wb_valid_o), 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_io_req", 32'(io_req_o), 0);
    check("rst_io_timeout", 32'(io_timeout_o), 0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++)
      do_txn(4'b0010, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b0, 5'd0, 1'b0, 0, 32'h0);

    do_txn(4'b0010, 32'h6, 2'b00, 1'b0, 32'h000000AB, 1'b0, 5'd1, 1'b0, 0, 32'h0);
    do_txn(4'b0010, 32'h4, 2'b10, 1'b0, 32'h80FF1234, 1'b0, 5'd1, 1'b0, 0, 32'h0);
    do_txn(4'b0001, 32'h7, 2'b00, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 0, 32'h0);
    do_txn(4'b0001, 32'h7, 2'b00, 1'b1, 32'h0, 1'b1, 5'd4, 1'b1, 0, 32'h0);
    do_txn(4'b0100, 32'h1000, 2'b10, 1'b0, 32'h0, 1'b1, 5'd5, 1'b1, 4, 32'h0000005A);
    do_txn(4'b1000, 32'h1004, 2'b10, 1'b0, 32'h12345678, 1'b1, 5'd6, 1'b0, 0, 32'h0);
    do_txn(4'b0100, 32'h1008, 2'b01, 1'b0, 32'h0, 1'b1, 5'd7, 1'b1, IO_TIMEOUT, 32'h0000C001);
    do_txn(4'b0011, 32'h8, 2'b01, 1'b0, 32'hBEEF, 1'b1, 5'd8, 1'b1, 0, 32'h0);
    do_txn(4'b0001, 32'h2, 2'b10, 1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 0, 32'h0);

    // Reset while an IO access is outstanding.
    io_read_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; io_write_i = 1'b0;
    alu_result_i = 32'h2000; byte_or_word_i = 2'b10; io_ack_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_pre_req", 32'(io_req_o), 1);
    rst_n = 1'b0;
    io_read_i = 1'b0;
    @(negedge clk);
    check("rst_mid_io_req", 32'(io_req_o), 0);
    check("rst_mid_stall", 32'(stall_o), 0);
    check("rst_mid_wb_valid", 32'(wb_valid_o), 0);
    rst_n = 1'b1;
    do_txn(4'b0000, 32'hCAFE0001, 2'b10, 1'b0, 32'h0, 1'b1, 5'd10, 1'b0, 0, 32'h0);

    for (int t = 0; t < 150; t++) begin
      fl = 4'($urandom);
      if ($urandom_range(0, 2) != 0) fl[3:2] = 2'b00;
      a = (fl[3] | fl[2]) ? $urandom : ((fl[1] | fl[0]) ? 32'($urandom_range(0, 63)) : $urandom);
      do_txn(fl, a, 2'($urandom), 1'($urandom), $urandom, 1'($urandom), 5'($urandom),
             $urandom_range(0, 3) != 0, int'($urandom_range(1, IO_TIMEOUT + 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage access controller. Consumes the registered EX/MEM control and data bundle and drives the data BRAM and the memory-mapped IO bus.
- Performs byte/half/word lane steering and load extraction with sign or zero extension.
- Stalls the pipeline while an access is outstanding.
- Produces a registered MEM/WB bundle with a valid strobe.

Parameters:
- ADDR_W, 14, word-address width of the data BRAM.
- IO_TIMEOUT, 255, maximum cycles to wait for io_ack_i before forced completion.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- reg_write_i  in  1  destination register write enable from EX/MEM.
- mem_or_io_to_reg_i  in  1  1 = writeback loaded data, 0 = writeback alu_result_i.
- mem_read_i, mem_write_i  in  1 each  BRAM load / store request.
- io_read_i, io_write_i  in  1 each  IO load / store request.
- byte_or_word_i  in  2  00 byte, 01 half, 10/11 word.
- load_unsigned_i  in  1  zero-extend sub-word loads.
- alu_result_i  in  32  effective address / ALU result.
- wdata_i  in  32  store data (rs2).
- rd_i  in  5  destination register.
- dmem_en_o  out  1  BRAM enable.
- dmem_we_o  out  4  BRAM byte write enables.
- dmem_addr_o  out  ADDR_W  BRAM word address, = alu_result_i[ADDR_W+1:2].
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_rdata_i  in  32  BRAM read data, valid 1 cycle after dmem_en_o.
- io_req_o  out  1  IO request; held until ack.
- io_we_o  out  1  IO write.
- io_addr_o  out  32  IO address, latched.
- io_wdata_o  out  32  IO store data, latched.
- io_ack_i  in  1  IO completion.
- io_rdata_i  in  32  IO read data, valid with io_ack_i.
- stall_o  out  1  combinational; upstream holds its bundle stable while high.
- wb_valid_o  out  1  MEM/WB bundle valid.
- wb_reg_write_o  out  1  writeback enable.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  32  writeback data.
- io_timeout_o  out  1  1-cycle pulse on IO timeout.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0: wb_*, io_req_o, io_timeout_o, timeout counter, latched fields. dmem_en_o, dmem_we_o and stall_o are also 0 while rst_n=0. Reset mid-access abandons it: io_req_o drops next cycle, no writeback.
- FSM states: IDLE, MEM_RD, IO_WAIT.
- IDLE, no request (all four request flags 0):
  - wb_valid_o=1 next cycle.
  - wb_data_o=alu_result_i, wb_reg_write_o=reg_write_i, wb_rd_o=rd_i.
  - stall_o=0.
- IDLE, mem_write_i:
  - dmem_en_o=1 this cycle with lane enables.
  - wb_valid_o=1 next cycle, wb_reg_write_o=0, stall_o=0.
- IDLE, mem_read_i:
  - dmem_en_o=1, stall_o=1 this cycle.
  - Latch rd, lane, size and unsigned flag; go to MEM_RD.
- MEM_RD:
  - Extract from dmem_rdata_i, stall_o=0.
  - Register the writeback; wb_valid_o=1 at next edge. Load-to-writeback latency is 2 cycles.
  - Return to IDLE.
- IDLE, io_read_i or io_write_i:
  - Latch address, data, size and rd.
  - io_req_o=1 from the next cycle; go to IO_WAIT. stall_o=1 this cycle.
- IO_WAIT:
  - stall_o=1 and io_req_o=1 until io_ack_i.
  - On ack: writeback of extracted io_rdata_i (reads) or wb_reg_write_o=0 (writes); wb_valid_o=1 next edge; io_req_o=0; go to IDLE.
  - Counter increments each IO_WAIT cycle. If it reaches IO_TIMEOUT without ack: complete with data 0 and pulse io_timeout_o.
  - Ack arriving in the same cycle the counter hits the limit counts as ack (no timeout).
- Request priority: io flags win over mem flags. For a read and write of the same kind both set, the write wins and no register writeback occurs.
- Store lanes:
  - byte: we=4'b0001<<addr[1:0], data replicated ×4.
  - half: we=4'b0011<<{addr[1],1'b0}, data replicated ×2.
  - word: we=4'b1111.
- Load extraction: shift right by 8×addr[1:0] (byte) or 16×addr[1] (half). Sign-extend unless load_unsigned_i. Word loads pass through unchanged.
- Misalignment (half with addr[0]=1, word with addr[1:0]≠0) behaves per the optional feature.
- wb_valid_o is a 1-cycle pulse per completed instruction; it is 0 in cycles where nothing completes.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no BRAM/IO activity.
  - Adds output misalign_o (1 bit), pulsed for 1 cycle with wb_valid_o. wb_reg_write_o=0.
  - misalign_o resets to 0.
- Undefined:
  - Low address bits are ignored, so the access is forced to the aligned word/half.
  - No misalign_o port.

Test Plan:
- sb to addr 0x6 with wdata 0x000000AB → dmem_we_o=4'b0100, dmem_wdata_o=0xABABABAB, no stall.
- lb from addr 0x7 with BRAM word 0x80FF1234, signed → wb_data_o=0xFFFFFF80 two cycles after request. lbu → 0x00000080. stall_o high exactly 1 cycle.
- IO read with io_ack_i after 3 cycles, io_rdata_i=0x0000005A → stall_o high 4 cycles, wb_data_o=0x5A, io_req_o drops the cycle after ack.
- IO write with no ack, IO_TIMEOUT=8 → io_timeout_o pulses after 8 wait cycles, FSM returns to IDLE, wb_reg_write_o=0.
- rst_n=0 asserted while in IO_WAIT → next cycle io_req_o=0, stall_o=0, wb_valid_o=0, FSM in IDLE.
- lw from addr 0x2 → with MEM_MISALIGN_TRAP_EN: misalign_o=1, dmem_en_o=0. Without: read of word address 0, normal writeback.
